// File: rtl/sm_result_formatter_if.sv
// Handshake and result bus between the arithmetic unit, the formatter and the display driver.
interface sm_result_formatter_if;
    logic        start;
    logic [16:0] answer_in;
    logic        ovw_in;
    logic        busy;
    logic        done;
    logic [19:0] digits;
    logic        sign;
    logic        err;
    logic [4:0]  blank;

    // Requester side: issues conversions and observes results
    modport master (
        output start, answer_in, ovw_in,
        input  busy, done, digits, sign, err, blank
    );

    // Formatter side
    modport slave (
        input  start, answer_in, ovw_in,
        output busy, done, digits, sign, err, blank
    );
endinterface

// File: rtl/sm_result_formatter.sv
// Sign-magnitude to BCD result formatter: captures a 17-bit sign-magnitude value,
// converts the magnitude with double dabble over 16 cycles, then publishes digits,
// sign, overflow flag and a leading-zero blanking mask in one FINISH cycle.
module sm_result_formatter #(
    parameter int unsigned MAG_WIDTH  = 16,
    parameter int unsigned NUM_DIGITS = 5
) (
    input logic                 clock,
    input logic                 reset,
    sm_result_formatter_if.slave bus
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(MAG_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAG_WIDTH - 1);
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS - 1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [MAG_WIDTH-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sign_cap_q, sign_cap_d;
    logic                  err_cap_q, err_cap_d;

    logic [BCD_W-1:0]      digits_q, digits_d;
    logic                  sign_q, sign_d;
    logic                  err_q, err_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [BCD_W-1:0]      bcd_corr;
    logic [BCD_W-1:0]      fin_digits;
    logic [NUM_DIGITS-1:0] blank_fin;
    logic                  lead;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sign_cap_q <= 1'b0;
            err_cap_q  <= 1'b0;
            digits_q   <= '0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
            blank_q    <= BLANK_RST;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            sign_cap_q <= sign_cap_d;
            err_cap_q  <= err_cap_d;
            digits_q   <= digits_d;
            sign_q     <= sign_d;
            err_q      <= err_d;
            blank_q    <= blank_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Add-3 correction per digit and the final digit/blanking values
    always_comb begin
        bcd_corr = bcd_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_corr[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        fin_digits = err_cap_q ? '0 : bcd_q;

        // A digit is blanked only if it and every more significant digit are zero;
        // the units digit is always shown.
        blank_fin = '0;
        lead      = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead         = lead & (fin_digits[4*i +: 4] == 4'd0);
            blank_fin[i] = lead;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        sign_cap_d = sign_cap_q;
        err_cap_d  = err_cap_q;
        digits_d   = digits_q;
        sign_d     = sign_q;
        err_d      = err_q;
        blank_d    = blank_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d      = bus.answer_in[MAG_WIDTH-1:0];
                    bcd_d      = '0;
                    sign_cap_d = bus.answer_in[MAG_WIDTH] & (|bus.answer_in[MAG_WIDTH-1:0]);
                    err_cap_d  = bus.ovw_in;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_corr, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                digits_d = fin_digits;
                sign_d   = sign_cap_q & ~err_cap_q;
                err_d    = err_cap_q;
                blank_d  = blank_fin;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.digits = digits_q;
    assign bus.sign   = sign_q;
    assign bus.err    = err_q;
    assign bus.blank  = blank_q;

endmodule
